// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: arbiter state encoding and default baud divisor.
package uart_tx_arbiter_pkg;

    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_select #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    int            cand;
    logic [IW-1:0] cidx;

    // Walk offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        idx     = '0;
        any_req = |req;
        cand    = 0;
        cidx    = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = IW'(cand);
            if (req[cidx]) begin
                idx = cidx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ message sources; a granted source owns the link until its
// last byte or until it stalls for TIMEOUT_CYCLES cycles. One cycle of arbitration latency.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int BITS_N         = 8,
    parameter int TIMEOUT_CYCLES = 4340,
    localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0][BITS_N-1:0]  req_data,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [BITS_N-1:0]               tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [IW-1:0]                   grant_id,
    output logic                            busy,
    output logic                            timeout_err
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          terr_q, terr_d;

    logic [IW-1:0] sel_idx;
    logic          any_req;
    logic          active;
    logic          g_valid;
    logic          g_last;
    logic [IW-1:0] g_next;

    rr_select #(.N(NUM_REQ), .IW(IW)) u_rr_select (
        .req     (req_valid),
        .ptr     (rr_q),
        .idx     (sel_idx),
        .any_req (any_req)
    );

    // Gating with rst keeps a byte offered during the reset cycle from being accepted.
    assign active   = (state_q == LOCKED) && !rst;
    assign g_valid  = req_valid[grant_q];
    assign g_last   = req_last[grant_q];
    assign g_next   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    assign busy        = (state_q == LOCKED);
    assign grant_id    = grant_q;
    assign timeout_err = terr_q;

    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (active) begin
            tx_data            = req_data[grant_q];
            tx_valid           = g_valid;
            req_ready[grant_q] = tx_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        stall_d = stall_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel_idx;
                    stall_d = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Backpressure with valid high is not a stall; only a silent owner times out.
                if (g_valid) begin
                    stall_d = '0;
                    if (tx_ready && g_last) begin
                        state_d = IDLE;
                        rr_d    = g_next;
                    end
                end else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    rr_d    = g_next;
                    stall_d = '0;
                    terr_d  = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            stall_q <= stall_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of message sources sharing one uart_tx.
REQ-002 Parameter BITS_N, default 8: byte width, matching uart_tx BITS_N.
REQ-003 Parameter TIMEOUT_CYCLES, default 4340 (10 bit times at CLKS_PER_BIT 434): maximum mid-message stall.
REQ-004 clk  input  1  system clock (50 MHz); one clock domain only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_data  input  NUM_REQ x BITS_N  byte offered by each requester.
REQ-007 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-008 req_last  input  NUM_REQ  marks the final byte of a requester's message.
REQ-009 req_ready  output  NUM_REQ  per-requester byte accepted.
REQ-010 tx_data  output  BITS_N  byte to uart_tx.
REQ-011 tx_valid  output  1  byte valid to uart_tx.
REQ-012 tx_ready  input  1  uart_tx ready to accept a byte.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of the current owner.
REQ-014 busy  output  1  high while a message is locked.
REQ-015 timeout_err  output  1  one-cycle pulse when a locked message is aborted.

Function
REQ-016 A transfer SHALL occur on any cycle where the granted requester's req_valid and tx_ready are both high.
REQ-017 The block SHALL use two states, IDLE and LOCKED.
REQ-018 In IDLE with any req_valid high, the block SHALL select the first requester at or after rr_ptr (modulo NUM_REQ) with req_valid high, register it into grant_id, and enter LOCKED on the next cycle.
REQ-019 IDLE SHALL drive tx_valid=0 and all req_ready=0, giving one cycle of arbitration latency.
REQ-020 In LOCKED, tx_data SHALL equal req_data[grant_id] and tx_valid SHALL equal req_valid[grant_id], combinationally.
REQ-021 In LOCKED, req_ready[grant_id] SHALL equal tx_ready; every other req_ready SHALL be 0.
REQ-022 A transfer with req_last[grant_id]=1 SHALL return the block to IDLE and set rr_ptr to (grant_id+1) mod NUM_REQ.
REQ-023 A non-granted requester SHALL never lose a byte: its req_ready stays 0 until it is granted.
REQ-024 In LOCKED, a stall counter SHALL increment each cycle req_valid[grant_id]=0 and clear on any cycle req_valid[grant_id]=1.
REQ-025 Backpressure (tx_ready=0 with valid high) SHALL NOT advance the stall counter.
REQ-026 When the stall counter reaches TIMEOUT_CYCLES-1 with valid still low, the block SHALL pulse timeout_err for one cycle, enter IDLE, and advance rr_ptr past grant_id.
REQ-027 The stall counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the counter SHALL never wrap.
REQ-028 busy SHALL be 1 exactly when the state is LOCKED.
REQ-029 A requester deasserting valid in IDLE before being granted SHALL simply not be selected; no error is raised.
REQ-030 A single-byte message (valid and last together) SHALL be legal.

Reset
REQ-031 On rst: state=IDLE, rr_ptr=0, grant_id=0, stall counter=0, timeout_err=0, busy=0, tx_valid=0, all req_ready=0.
REQ-032 rst asserted mid-message SHALL abandon the message without a timeout_err pulse; a byte presented in the reset cycle SHALL NOT be accepted.

Structure
REQ-033 The state enum (IDLE, LOCKED) and the default baud constant CLKS_PER_BIT_115200=434 SHALL live in the shared uart package used by uart_rx/uart_tx.
REQ-034 Round-robin selection SHALL be a sub-module rr_select (inputs req vector, pointer; outputs index and any_req), purely combinational.
REQ-035 The block SHALL instantiate no uart_tx; integration connects tx_* at the top level.

Verification
REQ-036 Requester 0 sends the 3-byte message 0x41,0x42,0x43 with tx_ready always 1 -> bytes appear in order on tx_data, busy drops the cycle after 0x43, and rr_ptr becomes 1.
REQ-037 Requesters 0, 1 and 2 all assert valid from IDLE with rr_ptr=0, each sending a 2-byte message -> grants occur in order 0,1,2, with no message interleaving.
REQ-038 With requester 1 granted, tx_ready is held low for 5000 cycles with valid high -> no timeout_err, and the byte transfers when tx_ready rises.
REQ-039 With requester 2 granted, valid is dropped after the first byte and held low for 4340 cycles -> timeout_err pulses once, the block enters IDLE, and requester 0 is granted next.
REQ-040 rst is asserted during the second byte of a message -> all outputs take their reset values the next cycle, and requester 0 is granted first afterwards.
REQ-041 Loopback test: arbiter drives uart_tx, which feeds uart_rx with PARITY_TYPE=0 -> 0xA5 and 0x3C are received with valid_out high and parity_error=0.
